alu_seq_ctrl: RTL and testbench

Command sequencer that owns the accumulator and drives the shared 8-bit ALU datapath (ADD/SUB/SHIFT/CMP/EXOR/BCMP/AND/NAND/OR/NOR). It accepts one command at a time over a valid/ready handshake and issues a single-cycle ALU strobe with operands and carry-in. It then waits a fixed ALU latency, writes the result back to the accumulator and returns result and flags over a second valid/ready handshake. It sits between the command source (bench or host logic) and the ALU core.

---
 rtl/alu_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_alu_seq_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Command sequencer owning the accumulator and carry flag C: accepts one command,
// strobes the shared ALU, waits ALU_LAT cycles, writes back and returns a response.
module alu_seq_ctrl #(
  parameter int ALU_LAT = 1  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_cin,
  input  logic       cmd_chain,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  output logic       alu_cin,
  output logic       alu_ce,
  input  logic [7:0] alu_result,
  input  logic       alu_cout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_cout,
  output logic       rsp_zero,
  output logic       rsp_err,
  output logic [7:0] acc
);

  localparam logic [3:0] OP_CMP   = 4'd3;
  localparam logic [3:0] OP_BCMP  = 4'd5;
  localparam logic [3:0] OP_LAST  = 4'd9;
  localparam logic [3:0] OP_LOAD  = 4'd10;
  localparam logic [3:0] OP_CLEAR = 4'd11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic       c_flag;

  // The carry reported with a response is always the flag value after that command.
  assign rsp_cout = c_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      c_flag    <= 1'b0;
      acc       <= '0;
      cmd_ready <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_cin   <= 1'b0;
      alu_ce    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // cmd_ready is held low for the first cycle out of reset.
          if (!cmd_ready) begin
            cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            cmd_ready <= 1'b0;
            rsp_err   <= 1'b0;
            if (cmd_op <= OP_LAST) begin
              alu_a   <= acc;
              alu_b   <= cmd_data;
              alu_op  <= cmd_op;
              alu_cin <= cmd_chain ? c_flag : cmd_cin;
              alu_ce  <= 1'b1;
              state   <= ISSUE;
            end else begin
              rsp_valid <= 1'b1;
              state     <= RESP;
              if (cmd_op == OP_LOAD) begin
                acc      <= cmd_data;
                rsp_data <= cmd_data;
                rsp_zero <= (cmd_data == 8'd0);
              end else if (cmd_op == OP_CLEAR) begin
                acc      <= '0;
                c_flag   <= 1'b0;
                rsp_data <= '0;
                rsp_zero <= 1'b1;
              end else begin
                rsp_err  <= 1'b1;
                rsp_data <= acc;
                rsp_zero <= (acc == 8'd0);
              end
            end
          end
        end

        ISSUE: begin
          alu_ce   <= 1'b0;
          wait_cnt <= 4'(ALU_LAT - 1);
          state    <= WAIT;
        end

        WAIT: begin
          if (wait_cnt == 4'd0) begin
            // Compares only touch the carry; everything else also writes the accumulator.
            rsp_data  <= alu_result;
            rsp_zero  <= (alu_result == 8'd0);
            c_flag    <= alu_cout;
            if (alu_op != OP_CMP && alu_op != OP_BCMP) begin
              acc <= alu_result;
            end
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: two instances (ALU_LAT 1 and 4), each with a
// behavioural ALU, a reference accumulator model and a decoupled response monitor.
module tb_alu_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       cout;
    logic       zero;
    logic       err;
    logic [7:0] acc;
    logic       is_alu;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic       cin;
    int         lat;
    int         acc_cyc;
    int         ce_cnt;
  } exp_t;

  // Reference ALU: returns {carry_out, result}.
  function automatic logic [8:0] alu_ref(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin);
    logic [7:0] r = 8'h00;
    case (op)
      4'd0: return {1'b0, a} + {1'b0, b} + {8'd0, cin};
      4'd1: return {1'b0, a} + {1'b0, ~b} + {8'd0, cin};
      4'd2: return {a, cin};
      4'd3: return {1'b0, a} + {1'b0, ~b} + 9'd1;
      4'd4: r = a ^ b;
      4'd5: r = ~(a ^ b);
      4'd6: r = a & b;
      4'd7: r = ~(a & b);
      4'd8: r = a | b;
      4'd9: r = ~(a | b);
      default: r = 8'h00;
    endcase
    return {^r, r};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 4;

    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_cin, cmd_chain;
    logic [3:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [3:0] alu_op;
    logic       alu_cin, alu_ce, alu_cout;
    logic       rsp_valid, rsp_ready, rsp_cout, rsp_zero, rsp_err;
    logic [7:0] rsp_data, acc;

    exp_t       q[$];
    logic [7:0] m_acc = 8'h00;
    logic       m_c = 1'b0;
    int         ce_exp = 0;
    int         rdy_mode = 0;
    bit         done = 1'b0;

    alu_seq_ctrl #(.ALU_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .cmd_cin(cmd_cin), .cmd_chain(cmd_chain),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin), .alu_ce(alu_ce),
      .alu_result(alu_result), .alu_cout(alu_cout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .acc(acc)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp_v);
      checkOutput($sformatf("lat%0d/%s", LAT, n), act, exp_v);
    endtask

    // Behavioural ALU: correct result only in the single cycle ALU_LAT after the strobe.
    initial begin : alu_model
      int cd = -1;
      logic [8:0] r = '0;
      alu_result = 8'h00;
      alu_cout   = 1'b0;
      forever begin
        @(posedge clk); #1;
        if (cd >= 0) cd--;
        if (cd == 0) {alu_cout, alu_result} = r;
        else         {alu_cout, alu_result} = 9'($urandom);
        if (alu_ce) begin
          r  = alu_ref(alu_op, alu_a, alu_b, alu_cin);
          cd = LAT;
        end
      end
    end

    initial begin : ready_driver
      rsp_ready = 1'b0;
      forever begin
        @(posedge clk); #1;
        case (rdy_mode)
          0:       rsp_ready = 1'b1;
          1:       rsp_ready = 1'($urandom_range(0, 1));
          default: rsp_ready = 1'b0;
        endcase
      end
    end

    initial begin : monitor
      logic prev_v = 1'b0;
      logic prev_ce = 1'b0;
      int   ce_cnt = 0;
      forever begin
        @(posedge clk); #2;
        if (alu_ce) begin
          chk("ce_single_cycle", prev_ce, 0);
          ce_cnt++;
        end
        prev_ce = alu_ce;
        if (q.size() > 0 && q[0].is_alu && !rsp_valid && cyc > q[0].acc_cyc) begin
          chk("alu_a", alu_a, q[0].a);
          chk("alu_b", alu_b, q[0].b);
          chk("alu_op", alu_op, q[0].op);
          chk("alu_cin", alu_cin, q[0].cin);
        end
        if (rsp_valid) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL lat%0d/unexpected_rsp: got rsp_valid=1, expected 0", LAT);
          end else begin
            if (!prev_v) chk("latency", cyc - q[0].acc_cyc, q[0].lat);
            chk("rsp_data", rsp_data, q[0].data);
            chk("rsp_cout", rsp_cout, q[0].cout);
            chk("rsp_zero", rsp_zero, q[0].zero);
            chk("rsp_err", rsp_err, q[0].err);
            chk("acc", acc, q[0].acc);
            chk("cmd_ready_busy", cmd_ready, 0);
            if (rsp_ready) begin
              chk("ce_count", ce_cnt, q[0].ce_cnt);
              void'(q.pop_front());
            end
          end
        end
        prev_v = rsp_valid;
      end
    end

    // Present a command, wait for acceptance and push the model's expected response.
    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] data,
                                 input logic cin, input logic chain);
      exp_t e;
      logic [8:0] r;
      int w = 0;
      cmd_op = op; cmd_data = data; cmd_cin = cin; cmd_chain = chain; cmd_valid = 1'b1;
      while (!cmd_ready && w < 300) begin
        @(posedge clk); #1;
        w++;
      end
      if (!cmd_ready) begin
        checks++;
        errors++;
        $display("[TB] FAIL lat%0d/accept_timeout: got cmd_ready=0, expected 1", LAT);
        cmd_valid = 1'b0;
        return;
      end
      e.is_alu = (op <= 4'd9);
      e.a = m_acc; e.b = data; e.op = op; e.cin = chain ? m_c : cin;
      e.err = 1'b0;
      if (op <= 4'd9) begin
        r = alu_ref(op, m_acc, data, e.cin);
        e.data = r[7:0];
        m_c = r[8];
        if (op != 4'd3 && op != 4'd5) m_acc = r[7:0];
        e.lat = LAT + 2;
        ce_exp++;
      end else if (op == 4'd10) begin
        m_acc = data; e.data = data; e.lat = 1;
      end else if (op == 4'd11) begin
        m_acc = 8'h00; m_c = 1'b0; e.data = 8'h00; e.lat = 1;
      end else begin
        e.data = m_acc; e.err = 1'b1; e.lat = 1;
      end
      e.cout = m_c; e.acc = m_acc; e.zero = (e.data == 8'h00);
      e.ce_cnt = ce_exp; e.acc_cyc = cyc;
      q.push_back(e);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_op = 4'($urandom); cmd_data = 8'($urandom);
    endtask

    task automatic waitIdle();
      int w = 0;
      while (q.size() != 0 && w < 300) begin
        @(posedge clk); #1;
        w++;
      end
      if (q.size() != 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL lat%0d/rsp_timeout: got %0d pending, expected 0", LAT, q.size());
        q.delete();
      end
    endtask

    task automatic checkResetOutputs(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 0);
      chk({tag, "_alu_ce"}, alu_ce, 0);
      chk({tag, "_alu_a"}, alu_a, 0);
      chk({tag, "_alu_b"}, alu_b, 0);
      chk({tag, "_alu_op"}, alu_op, 0);
      chk({tag, "_alu_cin"}, alu_cin, 0);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_data"}, rsp_data, 0);
      chk({tag, "_rsp_flags"}, {rsp_cout, rsp_zero, rsp_err}, 0);
      chk({tag, "_acc"}, acc, 0);
    endtask

    initial begin : stimulus
      int r;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_data = 8'd0;
      cmd_cin = 1'b0; cmd_chain = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs("reset");
      rst = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_reset", cmd_ready, 1);

      // LOAD then ADD, then carry generation and chaining
      applyStimulus(4'd10, 8'h05, 1'b0, 1'b0); waitIdle(); chk("acc_load5", acc, 8'h05);
      applyStimulus(4'd0, 8'h03, 1'b0, 1'b0);  waitIdle(); chk("acc_add3", acc, 8'h08);
      applyStimulus(4'd10, 8'h01, 1'b0, 1'b0); waitIdle();
      applyStimulus(4'd0, 8'hFF, 1'b0, 1'b0);  waitIdle(); chk("acc_wrap", acc, 8'h00);
      applyStimulus(4'd0, 8'h00, 1'b0, 1'b1);
      chk("chain_ce", alu_ce, 1);
      chk("chain_cin", alu_cin, 1);
      waitIdle(); chk("acc_chain", acc, 8'h01);

      // CMP leaves acc alone, CLEAR zeroes everything
      applyStimulus(4'd10, 8'h10, 1'b0, 1'b0); waitIdle();
      applyStimulus(4'd3, 8'h10, 1'b0, 1'b0);  waitIdle(); chk("acc_cmp", acc, 8'h10);
      applyStimulus(4'd11, 8'h5A, 1'b1, 1'b0); waitIdle(); chk("acc_clear", acc, 8'h00);

      // Illegal opcode: error held until the next command is accepted
      applyStimulus(4'd10, 8'h22, 1'b0, 1'b0); waitIdle();
      applyStimulus(4'd13, 8'hA5, 1'b0, 1'b0); waitIdle();
      chk("err_held", rsp_err, 1);
      applyStimulus(4'd10, 8'h33, 1'b0, 1'b0);
      chk("err_cleared", rsp_err, 0);
      waitIdle();

      // Stalled response: a second command must wait for the handshake
      rdy_mode = 2;
      applyStimulus(4'd8, 8'h0F, 1'b0, 1'b0);
      cmd_op = 4'd10; cmd_data = 8'h99; cmd_valid = 1'b1;
      repeat (LAT + 7) begin
        @(posedge clk); #1;
        chk("ready_low_stall", cmd_ready, 0);
      end
      rdy_mode = 0;
      applyStimulus(4'd10, 8'h99, 1'b0, 1'b0); waitIdle(); chk("acc_after_stall", acc, 8'h99);

      // Randomized traffic with random response back-pressure
      rdy_mode = 1;
      repeat (40) begin
        r = $urandom_range(0, 19);
        if (r < 12)      cmd_op = 4'(r % 10);
        else if (r < 16) cmd_op = 4'd10;
        else if (r < 18) cmd_op = 4'd11;
        else             cmd_op = 4'(12 + $urandom_range(0, 3));
        applyStimulus(cmd_op, 8'($urandom), 1'($urandom), 1'($urandom));
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      waitIdle();

      // Reset in the middle of an ALU command
      rdy_mode = 0;
      applyStimulus(4'd10, 8'h44, 1'b0, 1'b0); waitIdle();
      applyStimulus(4'd0, 8'h11, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      q.delete();
      m_acc = 8'h00; m_c = 1'b0;
      @(posedge clk); #1;
      checkResetOutputs("midwait_reset");
      @(posedge clk); #1;
      rst = 1'b0;
      chk("ready_still_low", cmd_ready, 0);
      @(posedge clk); #1;
      chk("ready_one_after_reset", cmd_ready, 1);
      repeat (LAT + 3) begin
        @(posedge clk); #1;
        chk("no_rsp_after_reset", rsp_valid, 0);
      end
      applyStimulus(4'd0, 8'h07, 1'b1, 1'b1); waitIdle(); chk("acc_after_reset", acc, 8'h07);
      done = 1'b1;
    end
  end

  initial begin : finisher
    wait (lane[0].done && lane[1].done);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    checks++;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected both lanes done");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
